// File: rtl/parity_rr_scheduler.sv
// parity_rr_scheduler: round-robin sharing of one 4-bit parity unit among N_REQ requesters
module parity_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int ERR_CNT_W = 8,
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [N_REQ-1:0]     i_req_mode,
  input  logic [4*N_REQ-1:0]   i_req_data,
  output logic [N_REQ-1:0]     o_req_ack,
  output logic [3:0]           o_pu_a,
  output logic                 o_pu_ctrl,
  input  logic                 i_pu_y,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [IDW-1:0]       o_rsp_id,
  output logic                 o_rsp_y,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  input  logic                 i_clr_err,
  output logic                 o_busy
);
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
  state_t               r_state, w_next;
  logic [IDW-1:0]       r_rr_ptr, r_gid, w_pick, w_next_ptr;
  logic [31:0]          w_t;
  logic                 w_grant;
  logic [3:0]           r_pu_a;
  logic                 r_pu_ctrl, r_rsp_valid, r_rsp_y;
  logic [IDW-1:0]       r_rsp_id;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  // Scan from rr_ptr+N-1 down to rr_ptr so the nearest asserted request wins
  always_comb begin
    w_pick = '0;
    w_t = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_t = 32'(r_rr_ptr) + 32'(k);
      if (w_t >= 32'(N_REQ)) w_t = w_t - 32'(N_REQ);
      if (i_req[w_t[IDW-1:0]]) w_pick = w_t[IDW-1:0];
    end
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (|i_req ? DRIVE : IDLE) :
             (r_state == DRIVE) ? RESP : (i_rsp_ready ? IDLE : RESP);
  end
  assign w_grant    = (r_state == IDLE) && |i_req && !rst;
  assign w_next_ptr = (r_gid == IDW'(N_REQ - 1)) ? '0 : r_gid + 1'b1;
  assign o_req_ack  = w_grant ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_pick) : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_gid       <= '0;
      r_pu_a      <= '0;
      r_pu_ctrl   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_y     <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      if (w_grant) begin
        r_pu_a    <= i_req_data[{w_pick, 2'b00} +: 4];
        r_pu_ctrl <= i_req_mode[w_pick];
        r_gid     <= w_pick;
      end
      if (r_state == DRIVE) begin
        r_rsp_y     <= i_pu_y;
        r_rsp_id    <= r_gid;
        r_rsp_valid <= 1'b1;
      end
      if (r_state == RESP && i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_rr_ptr    <= w_next_ptr;
      end
      if (i_clr_err) r_err_cnt <= '0;
      else if (r_state == DRIVE && r_pu_ctrl && i_pu_y && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end
  assign o_pu_a      = r_pu_a;
  assign o_pu_ctrl   = r_pu_ctrl;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_y     = r_rsp_y;
  assign o_err_cnt   = r_err_cnt;
  assign o_busy      = (r_state != IDLE);
endmodule

// File: tb/tb_parity_rr_scheduler.sv
// tb_parity_rr_scheduler: directed vectors with a response scoreboard for parity_rr_scheduler
module tb_parity_rr_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0, req_mode = '0, req_ack;
  logic [15:0] req_data = '0;
  logic [3:0] pu_a;
  logic       pu_ctrl, pu_y, rsp_valid, rsp_y, busy;
  logic       rsp_ready = 1'b1, clr_err = 1'b0;
  logic [1:0] rsp_id;
  logic [7:0] err_cnt;
  int checks = 0, errors = 0;
  int q[$];

  parity_rr_scheduler #(.N_REQ(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_req_mode(req_mode), .i_req_data(req_data),
    .o_req_ack(req_ack), .o_pu_a(pu_a), .o_pu_ctrl(pu_ctrl), .i_pu_y(pu_y),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id), .o_rsp_y(rsp_y),
    .o_err_cnt(err_cnt), .i_clr_err(clr_err), .o_busy(busy)
  );

  assign pu_y = ^pu_a;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("unexpected_rsp", int'(rsp_id) * 2 + int'(rsp_y), -1);
      else chk("rsp_id_y", int'(rsp_id) * 2 + int'(rsp_y), q.pop_front());
    end
  end

  task automatic chk_zero(input string name);
    chk({name, "_ack"}, req_ack, 0);
    chk({name, "_pu"}, {pu_a, pu_ctrl}, 0);
    chk({name, "_rsp"}, {rsp_valid, rsp_id, rsp_y}, 0);
    chk({name, "_err"}, err_cnt, 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic issue(input int id, input logic mode, input logic [3:0] w, input logic y, input logic clr);
    @(posedge clk); #1;
    req = 4'(1 << id);
    req_mode[id] = mode;
    req_data[4*id +: 4] = w;
    q.push_back(id * 2 + int'(y));
    @(negedge clk);
    chk("ack", req_ack, 1 << id);
    @(posedge clk); #1;
    req = '0;
    clr_err = clr;
    @(negedge clk);
    chk("pu_a", pu_a, w);
    chk("pu_ctrl", pu_ctrl, mode);
    @(posedge clk); #1;
    clr_err = 1'b0;
    wait_idle();
  endtask

  initial begin
    do_reset();
    // basic generate and check transactions
    issue(0, 1'b0, 4'b1011, 1'b1, 1'b0);
    chk("err_after_gen", err_cnt, 0);
    issue(2, 1'b1, 4'b0111, 1'b1, 1'b0);
    chk("err_after_fail", err_cnt, 1);
    issue(2, 1'b1, 4'b0110, 1'b0, 1'b0);
    chk("err_after_pass", err_cnt, 1);
    // all four requesting: fair rotation, grants 3 cycles apart
    do_reset();
    @(posedge clk); #1;
    req_mode = '0;
    req_data = {4'b1111, 4'b0111, 4'b0011, 4'b0001};
    req = 4'hF;
    foreach (q[i]) ;
    q.push_back(0 * 2 + 1); q.push_back(1 * 2 + 0); q.push_back(2 * 2 + 1);
    q.push_back(3 * 2 + 0); q.push_back(0 * 2 + 1);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      chk("rr_ack", req_ack, (c % 3 == 0) ? (1 << ((c / 3) % 4)) : 0);
    end
    @(posedge clk); #1;
    req = '0;
    wait_idle();
    // backpressure: response held stable, no grant while waiting
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_data = {4'b0000, 4'b1100, 4'b1000, 4'b0000};
    req = 4'b0110;
    q.push_back(1 * 2 + 1); q.push_back(2 * 2 + 0);
    @(negedge clk);
    chk("bp_ack", req_ack, 4'b0010);
    @(posedge clk);
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_rsp", {rsp_valid, rsp_id, rsp_y}, {1'b1, 2'd1, 1'b1});
      chk("bp_hold_pu", {pu_a, pu_ctrl}, {4'b1000, 1'b0});
      chk("bp_no_ack", req_ack, 0);
      @(posedge clk);
    end
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_idle", busy, 0);
    chk("bp_next_ack", req_ack, 4'b0100);
    @(posedge clk); #1;
    req = '0;
    wait_idle();
    // saturating error counter and clear priority
    for (int i = 0; i < 255; i++) issue(0, 1'b1, 4'b0001, 1'b1, 1'b0);
    chk("err_255", err_cnt, 255);
    issue(0, 1'b1, 4'b0001, 1'b1, 1'b0);
    chk("err_sat", err_cnt, 255);
    issue(0, 1'b1, 4'b0001, 1'b1, 1'b1);
    chk("err_clr_wins", err_cnt, 0);
    issue(0, 1'b1, 4'b1110, 1'b1, 1'b0);
    chk("err_after_clr", err_cnt, 1);
    // asynchronous reset during DRIVE aborts the grant
    @(posedge clk); #1;
    req_mode = 4'b0010;
    req_data = {4'b0000, 4'b0000, 4'b0001, 4'b0000};
    req = 4'b0010;
    @(negedge clk);
    chk("abort_ack", req_ack, 4'b0010);
    @(posedge clk); #1;
    req = '0;
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_aborted_rsp", rsp_valid, 0);
    end
    // pointer restarts at 0 after reset
    @(posedge clk); #1;
    req_mode = '0;
    req_data = {4'b1110, 4'b0000, 4'b0000, 4'b0000};
    req = 4'b1001;
    q.push_back(0 * 2 + 0); q.push_back(3 * 2 + 1);
    @(negedge clk);
    chk("post_rst_ack0", req_ack, 4'b0001);
    @(posedge clk); #1;
    req = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_ack3", req_ack, 4'b1000);
    @(posedge clk); #1;
    req = '0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
